// File: rtl/ascon_aead_core.sv
// Ascon-128 AEAD engine: sequencing FSM, round/block counters and unrolled permutation datapath.
// Optional tag compare on decrypt is enabled by defining ASCON_TAG_CHECK_EN.
module ascon_aead_core #(
  parameter int unsigned NB_AD   = 1,
  parameter int unsigned NB_DATA = 4,
  parameter int unsigned UNROLL  = 1,
  parameter logic [63:0] IV      = 64'h80400C0600000000
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic         mode_i,
  input  logic [127:0] key_i,
  input  logic [127:0] nonce_i,
  input  logic [63:0]  data_i,
  input  logic         data_valid_i,
  output logic         data_ready_o,
  output logic [63:0]  cipher_o,
  output logic         cipher_valid_o,
  input  logic         cipher_ready_i,
  output logic [127:0] tag_o,
  output logic         end_o,
  output logic         busy_o
`ifdef ASCON_TAG_CHECK_EN
  ,
  input  logic [127:0] tag_i,
  output logic         tag_ok_o
`endif
);

  generate
    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 3 || UNROLL == 6)) begin : g_bad_unroll
      $error("ascon_aead_core: UNROLL must be 1, 2, 3 or 6");
    end
  endgenerate

  localparam logic [3:0] RC_STEP   = 4'(UNROLL);
  localparam logic [7:0] AD_LAST   = 8'(NB_AD - 1);
  localparam logic [7:0] DATA_LAST = 8'(NB_DATA - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_WAIT_AD, S_PROC_AD, S_WAIT_DATA, S_PROC_DATA, S_FINAL, S_DONE
  } state_t;

  state_t         r_state;
  logic [319:0]   r_s;
  logic [3:0]     r_rc;
  logic [7:0]     r_blk;
  logic           r_last;
  logic           r_kx;
  logic [127:0]   r_key;
  logic           r_mode;
  logic           r_ready;
  logic [63:0]    r_cipher;
  logic           r_cvalid;
  logic [127:0]   r_tag;
  logic           r_end;
  logic           r_busy;
`ifdef ASCON_TAG_CHECK_EN
  logic [127:0]   r_tag_in;
  logic           r_tag_ok;
`endif

  logic [319:0]   w_perm;
  logic [3:0]     w_rbase;
  logic [3:0]     w_rlen;
  logic           w_last_round;
  logic           w_stall;
  logic           w_xfer;
  logic [63:0]    w_x0;
  logic [127:0]   w_tag;

  function automatic logic [63:0] ror64(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] r);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    {x0, x1, x2, x3, x4} = s;
    x2 = x2 ^ {56'd0, ~r, r};
    x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
    x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
    x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
    x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
    x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
    x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
    x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  // p^b runs the last six round constants of p^a
  assign w_rbase      = (r_state == S_PROC_AD || r_state == S_PROC_DATA) ? 4'd6 : 4'd0;
  assign w_rlen       = (r_state == S_PROC_AD || r_state == S_PROC_DATA) ? 4'd6 : 4'd12;
  assign w_last_round = ((r_rc + RC_STEP) == w_rlen);
  assign w_stall      = r_cvalid & ~cipher_ready_i;
  assign w_xfer       = data_valid_i & data_ready_o;
  assign w_x0         = r_s[319:256];
  assign w_tag        = w_perm[127:0] ^ r_key;

  always_comb begin
    w_perm = r_s;
    for (int k = 0; k < UNROLL; k++) begin
      w_perm = ascon_round(w_perm, w_rbase + r_rc + 4'(k));
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state  <= S_IDLE;
      r_s      <= '0;
      r_rc     <= '0;
      r_blk    <= '0;
      r_last   <= 1'b0;
      r_kx     <= 1'b0;
      r_key    <= '0;
      r_mode   <= 1'b0;
      r_ready  <= 1'b0;
      r_cipher <= '0;
      r_cvalid <= 1'b0;
      r_tag    <= '0;
      r_end    <= 1'b0;
      r_busy   <= 1'b0;
`ifdef ASCON_TAG_CHECK_EN
      r_tag_in <= '0;
      r_tag_ok <= 1'b0;
`endif
    end else begin
      r_end <= 1'b0;
      if (r_cvalid && cipher_ready_i) r_cvalid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_key   <= key_i;
            r_mode  <= mode_i;
            r_s     <= {IV, key_i, nonce_i};
            r_rc    <= '0;
            r_blk   <= '0;
            r_tag   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_INIT;
`ifdef ASCON_TAG_CHECK_EN
            r_tag_in <= tag_i;
            r_tag_ok <= 1'b0;
`endif
          end
        end
        S_INIT: begin
          r_s  <= w_perm;
          r_rc <= r_rc + RC_STEP;
          if (w_last_round) begin
            r_rc    <= '0;
            r_ready <= 1'b1;
            if (NB_AD > 0) begin
              r_s     <= w_perm ^ {192'd0, r_key};
              r_state <= S_WAIT_AD;
            end else begin
              r_s     <= w_perm ^ {192'd0, r_key} ^ 320'd1;
              r_state <= S_WAIT_DATA;
            end
          end
        end
        S_WAIT_AD: begin
          if (w_xfer) begin
            r_s[319:256] <= w_x0 ^ data_i;
            r_ready      <= 1'b0;
            r_last       <= (r_blk == AD_LAST);
            r_blk        <= r_blk + 8'd1;
            r_state      <= S_PROC_AD;
          end
        end
        S_PROC_AD: begin
          r_s  <= w_perm;
          r_rc <= r_rc + RC_STEP;
          if (w_last_round) begin
            r_rc    <= '0;
            r_ready <= 1'b1;
            if (r_last) begin
              r_s     <= w_perm ^ 320'd1;
              r_blk   <= '0;
              r_state <= S_WAIT_DATA;
            end else begin
              r_state <= S_WAIT_AD;
            end
          end
        end
        S_WAIT_DATA: begin
          if (w_xfer) begin
            r_cipher     <= w_x0 ^ data_i;
            r_cvalid     <= 1'b1;
            r_s[319:256] <= r_mode ? data_i : (w_x0 ^ data_i);
            r_ready      <= 1'b0;
            r_blk        <= r_blk + 8'd1;
            if (r_blk == DATA_LAST) begin
              r_kx    <= 1'b1;
              r_state <= S_FINAL;
            end else begin
              r_state <= S_PROC_DATA;
            end
          end
        end
        S_PROC_DATA: begin
          if (!w_stall) begin
            r_s  <= w_perm;
            r_rc <= r_rc + RC_STEP;
            if (w_last_round) begin
              r_rc    <= '0;
              r_ready <= 1'b1;
              r_state <= S_WAIT_DATA;
            end
          end
        end
        S_FINAL: begin
          // the key is folded into x1,x2 on a cycle of its own before p^a starts
          if (!w_stall) begin
            if (r_kx) begin
              r_s  <= r_s ^ {64'd0, r_key, 128'd0};
              r_kx <= 1'b0;
            end else begin
              r_s  <= w_perm;
              r_rc <= r_rc + RC_STEP;
              if (w_last_round) begin
                r_rc    <= '0;
                r_tag   <= w_tag;
                r_end   <= 1'b1;
                r_state <= S_DONE;
`ifdef ASCON_TAG_CHECK_EN
                r_tag_ok <= r_mode & (w_tag == r_tag_in);
`endif
              end
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data_ready_o   = r_ready & ~r_cvalid;
  assign cipher_o       = r_cipher;
  assign cipher_valid_o = r_cvalid;
  assign tag_o          = r_tag;
  assign end_o          = r_end;
  assign busy_o         = r_busy;
`ifdef ASCON_TAG_CHECK_EN
  assign tag_ok_o       = r_tag_ok;
`endif

endmodule

// File: tb/tb_ascon_aead_core.sv
// Bench for ascon_aead_core: five instances (unroll sweep, NB_AD=0 boundary) against an S-box table model.
module tb_ascon_aead_core;

  localparam logic [63:0] IV_A128 = 64'h80400C0600000000;

  logic         clk = 1'b0;
  logic         rst;
  logic [4:0]   start_vec;
  logic [4:0]   valid_vec;
  logic         mode;
  logic [127:0] key, nonce, tag_in;
  logic [63:0]  data;
  logic         cready;

  logic         rdy  [5];
  logic         cval [5];
  logic         endv [5];
  logic         busy [5];
  logic [63:0]  cph  [5];
  logic [127:0] tg   [5];
  logic         tok  [5];

  int n_vec = 0;
  int n_bad = 0;

  logic [4:0]  sbox [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                             5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                             5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                             5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  logic [63:0]  m_ad [4], m_din [4], m_out [4], o_out [4], pt_save [4], ct_save [4];
  logic [127:0] m_tag, o_tag, tag_save;

  always #5 clk = ~clk;

  ascon_aead_core #(.NB_AD(1), .NB_DATA(4), .UNROLL(1)) u_dut (
    .clock_i(clk), .reset_i(rst), .start_i(start_vec[0]), .mode_i(mode), .key_i(key), .nonce_i(nonce),
    .data_i(data), .data_valid_i(valid_vec[0]), .data_ready_o(rdy[0]), .cipher_o(cph[0]),
    .cipher_valid_o(cval[0]), .cipher_ready_i(cready), .tag_o(tg[0]), .end_o(endv[0]), .busy_o(busy[0])
`ifdef ASCON_TAG_CHECK_EN
    , .tag_i(tag_in), .tag_ok_o(tok[0])
`endif
  );
  ascon_aead_core #(.NB_AD(1), .NB_DATA(4), .UNROLL(2)) u_u2 (
    .clock_i(clk), .reset_i(rst), .start_i(start_vec[1]), .mode_i(mode), .key_i(key), .nonce_i(nonce),
    .data_i(data), .data_valid_i(valid_vec[1]), .data_ready_o(rdy[1]), .cipher_o(cph[1]),
    .cipher_valid_o(cval[1]), .cipher_ready_i(cready), .tag_o(tg[1]), .end_o(endv[1]), .busy_o(busy[1])
`ifdef ASCON_TAG_CHECK_EN
    , .tag_i(tag_in), .tag_ok_o(tok[1])
`endif
  );
  ascon_aead_core #(.NB_AD(1), .NB_DATA(4), .UNROLL(3)) u_u3 (
    .clock_i(clk), .reset_i(rst), .start_i(start_vec[2]), .mode_i(mode), .key_i(key), .nonce_i(nonce),
    .data_i(data), .data_valid_i(valid_vec[2]), .data_ready_o(rdy[2]), .cipher_o(cph[2]),
    .cipher_valid_o(cval[2]), .cipher_ready_i(cready), .tag_o(tg[2]), .end_o(endv[2]), .busy_o(busy[2])
`ifdef ASCON_TAG_CHECK_EN
    , .tag_i(tag_in), .tag_ok_o(tok[2])
`endif
  );
  ascon_aead_core #(.NB_AD(1), .NB_DATA(4), .UNROLL(6)) u_u6 (
    .clock_i(clk), .reset_i(rst), .start_i(start_vec[3]), .mode_i(mode), .key_i(key), .nonce_i(nonce),
    .data_i(data), .data_valid_i(valid_vec[3]), .data_ready_o(rdy[3]), .cipher_o(cph[3]),
    .cipher_valid_o(cval[3]), .cipher_ready_i(cready), .tag_o(tg[3]), .end_o(endv[3]), .busy_o(busy[3])
`ifdef ASCON_TAG_CHECK_EN
    , .tag_i(tag_in), .tag_ok_o(tok[3])
`endif
  );
  ascon_aead_core #(.NB_AD(0), .NB_DATA(1), .UNROLL(1)) u_small (
    .clock_i(clk), .reset_i(rst), .start_i(start_vec[4]), .mode_i(mode), .key_i(key), .nonce_i(nonce),
    .data_i(data), .data_valid_i(valid_vec[4]), .data_ready_o(rdy[4]), .cipher_o(cph[4]),
    .cipher_valid_o(cval[4]), .cipher_ready_i(cready), .tag_o(tg[4]), .end_o(endv[4]), .busy_o(busy[4])
`ifdef ASCON_TAG_CHECK_EN
    , .tag_i(tag_in), .tag_ok_o(tok[4])
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // Permutation built from the 5-bit S-box table applied column by column
  function automatic logic [319:0] model_perm(input logic [319:0] st, input int nr);
    logic [63:0] x [5];
    logic [4:0]  col, o;
    for (int i = 0; i < 5; i++) x[i] = st[319 - 64*i -: 64];
    for (int r = 12 - nr; r < 12; r++) begin
      x[2] = x[2] ^ 64'((15 - r) * 16 + r);
      for (int b = 0; b < 64; b++) begin
        col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
        o = sbox[col];
        x[0][b] = o[4]; x[1][b] = o[3]; x[2][b] = o[2]; x[3][b] = o[1]; x[4][b] = o[0];
      end
      x[0] = x[0] ^ ror(x[0], 19) ^ ror(x[0], 28);
      x[1] = x[1] ^ ror(x[1], 61) ^ ror(x[1], 39);
      x[2] = x[2] ^ ror(x[2], 1)  ^ ror(x[2], 6);
      x[3] = x[3] ^ ror(x[3], 10) ^ ror(x[3], 17);
      x[4] = x[4] ^ ror(x[4], 7)  ^ ror(x[4], 41);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  task automatic model_run(input logic md, input logic [127:0] k, input logic [127:0] n,
                           input int nad, input int nd);
    logic [319:0] s;
    s = model_perm({IV_A128, k, n}, 12);
    s[127:0] = s[127:0] ^ k;
    for (int i = 0; i < nad; i++) begin
      s[319:256] = s[319:256] ^ m_ad[i];
      s = model_perm(s, 6);
    end
    s[0] = ~s[0];
    for (int i = 0; i < nd; i++) begin
      m_out[i] = s[319:256] ^ m_din[i];
      s[319:256] = md ? m_din[i] : m_out[i];
      if (i < nd - 1) s = model_perm(s, 6);
    end
    s[255:128] = s[255:128] ^ k;
    s = model_perm(s, 12);
    m_tag = s[127:0] ^ k;
  endtask

  task automatic run_dut(input int sel, input logic md, input logic [127:0] k, input logic [127:0] n,
                         input int nad, input int nd, input int u, input int bp_blk,
                         input bit poke, input int rst_blk);
    int cnt;
    int j;
    logic [63:0] held;
    @(negedge clk);
    mode = md; key = k; nonce = n; start_vec = 5'(1 << sel);
    @(posedge clk);
    cnt = 1;
    @(negedge clk);
    start_vec = '0;
    chk("busy_after_start", 128'(busy[sel]), 128'd1);
    while (!rdy[sel] && cnt < 200) begin @(posedge clk); cnt++; @(negedge clk); end
    chk("start_to_ready", 128'(cnt), 128'(12 / u + 1));
    for (int i = 0; i < nad + nd; i++) begin
      cnt = 0;
      while (!rdy[sel] && cnt < 200) begin @(posedge clk); cnt++; @(negedge clk); end
      chk("ready_wait", 128'(rdy[sel]), 128'd1);
      data = (i < nad) ? m_ad[i] : m_din[i - nad];
      valid_vec = 5'(1 << sel);
      @(posedge clk);
      @(negedge clk);
      valid_vec = '0;
      if (i >= nad) begin
        j = i - nad;
        chk("cipher_valid", 128'(cval[sel]), 128'd1);
        chk("cipher_blk", 128'(cph[sel]), 128'(m_out[j]));
        o_out[j] = cph[sel];
        if (poke && j == 0) begin
          start_vec = 5'(1 << sel); key = ~k;
          @(posedge clk); @(negedge clk);
          start_vec = '0; key = k;
          chk("busy_after_poke", 128'(busy[sel]), 128'd1);
        end
        if (j == bp_blk) begin
          cready = 1'b0;
          held = cph[sel];
          repeat (5) begin
            @(posedge clk); @(negedge clk);
            chk("bp_valid", 128'(cval[sel]), 128'd1);
            chk("bp_stable", 128'(cph[sel]), 128'(held));
            chk("bp_ready", 128'(rdy[sel]), 128'd0);
          end
          cready = 1'b1;
        end
        if (j == rst_blk) begin
          rst = 1'b1;
          @(posedge clk); @(negedge clk);
          chk("rst_busy", 128'(busy[sel]), 128'd0);
          chk("rst_cvalid", 128'(cval[sel]), 128'd0);
          chk("rst_cipher", 128'(cph[sel]), 128'd0);
          chk("rst_ready", 128'(rdy[sel]), 128'd0);
          chk("rst_tag", tg[sel], 128'd0);
          chk("rst_end", 128'(endv[sel]), 128'd0);
          rst = 1'b0;
          return;
        end
        if (j == nd - 1) begin
          cnt = 1;
          while (!endv[sel] && cnt < 200) begin @(posedge clk); cnt++; @(negedge clk); end
          chk("last_to_end", 128'(cnt), 128'(2 + 12 / u));
          chk("tag", tg[sel], m_tag);
`ifdef ASCON_TAG_CHECK_EN
          chk("tag_ok", 128'(tok[sel]), 128'(md && (m_tag == tag_in)));
`endif
          o_tag = tg[sel];
          @(posedge clk); @(negedge clk);
          chk("end_pulse", 128'(endv[sel]), 128'd0);
          chk("idle_busy", 128'(busy[sel]), 128'd0);
          chk("tag_hold", tg[sel], m_tag);
        end
      end
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] k, n;
    logic md;
    rst = 1'b1; start_vec = '0; valid_vec = '0; mode = 1'b0; key = '0; nonce = '0;
    data = '0; cready = 1'b1; tag_in = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 128'(busy[0]), 128'd0);
    chk("reset_ready", 128'(rdy[0]), 128'd0);
    chk("reset_cvalid", 128'(cval[0]), 128'd0);
    chk("reset_tag", tg[0], 128'd0);
    chk("reset_end", 128'(endv[0]), 128'd0);
    rst = 1'b0;

    // KAT-style encrypt
    k = 128'h000102030405060708090A0B0C0D0E0F;
    n = 128'h000102030405060708090A0B0C0D0E0F;
    m_ad[0] = 64'h3230323280000000;
    for (int i = 0; i < 4; i++) begin m_din[i] = {$urandom, $urandom}; pt_save[i] = m_din[i]; end
    model_run(1'b0, k, n, 1, 4);
    run_dut(0, 1'b0, k, n, 1, 4, 1, -1, 1'b0, -1);
    for (int i = 0; i < 4; i++) ct_save[i] = o_out[i];
    tag_save = o_tag;

    // Round trip decrypt
    for (int i = 0; i < 4; i++) m_din[i] = ct_save[i];
    model_run(1'b1, k, n, 1, 4);
    tag_in = m_tag;
    run_dut(0, 1'b1, k, n, 1, 4, 1, -1, 1'b0, -1);
    for (int i = 0; i < 4; i++) chk("roundtrip_pt", 128'(o_out[i]), 128'(pt_save[i]));
    chk("roundtrip_tag", o_tag, tag_save);
`ifdef ASCON_TAG_CHECK_EN
    tag_in = m_tag ^ 128'd1;
    run_dut(0, 1'b1, k, n, 1, 4, 1, -1, 1'b0, -1);
`endif

    // Unroll sweep on the same encrypt vector
    for (int i = 0; i < 4; i++) m_din[i] = pt_save[i];
    model_run(1'b0, k, n, 1, 4);
    run_dut(1, 1'b0, k, n, 1, 4, 2, -1, 1'b0, -1);
    chk("sweep_u2_tag", o_tag, tag_save);
    run_dut(2, 1'b0, k, n, 1, 4, 3, -1, 1'b0, -1);
    chk("sweep_u3_tag", o_tag, tag_save);
    run_dut(3, 1'b0, k, n, 1, 4, 6, -1, 1'b0, -1);
    chk("sweep_u6_tag", o_tag, tag_save);

    // Backpressure after block 2
    k = rnd128(); n = rnd128(); m_ad[0] = {$urandom, $urandom};
    for (int i = 0; i < 4; i++) m_din[i] = {$urandom, $urandom};
    model_run(1'b0, k, n, 1, 4);
    run_dut(0, 1'b0, k, n, 1, 4, 1, 1, 1'b0, -1);

    // No AD, single block
    k = rnd128(); n = rnd128(); m_din[0] = {$urandom, $urandom};
    model_run(1'b0, k, n, 0, 1);
    run_dut(4, 1'b0, k, n, 0, 1, 1, -1, 1'b0, -1);

    // start_i while busy is ignored
    k = rnd128(); n = rnd128(); m_ad[0] = {$urandom, $urandom};
    for (int i = 0; i < 4; i++) m_din[i] = {$urandom, $urandom};
    model_run(1'b0, k, n, 1, 4);
    run_dut(0, 1'b0, k, n, 1, 4, 1, -1, 1'b1, -1);

    // Reset mid PROC_DATA, then a clean run
    run_dut(0, 1'b0, k, n, 1, 4, 1, -1, 1'b0, 1);
    run_dut(0, 1'b0, k, n, 1, 4, 1, -1, 1'b0, -1);

    // Random mixed-mode runs across instances
    for (int t = 0; t < 4; t++) begin
      k = rnd128(); n = rnd128(); md = 1'($urandom_range(0, 1));
      m_ad[0] = {$urandom, $urandom};
      for (int i = 0; i < 4; i++) m_din[i] = {$urandom, $urandom};
      model_run(md, k, n, 1, 4);
      tag_in = m_tag;
      case (t)
        0: run_dut(0, md, k, n, 1, 4, 1, -1, 1'b0, -1);
        1: run_dut(1, md, k, n, 1, 4, 2, 2, 1'b0, -1);
        2: run_dut(2, md, k, n, 1, 4, 3, -1, 1'b0, -1);
        default: run_dut(3, md, k, n, 1, 4, 6, 0, 1'b0, -1);
      endcase
    end
    k = rnd128(); n = rnd128(); m_din[0] = {$urandom, $urandom};
    model_run(1'b1, k, n, 0, 1);
    tag_in = m_tag;
    run_dut(4, 1'b1, k, n, 0, 1, 1, -1, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
